// File: rtl/assoc_tag_cache.sv
// Set-associative tag directory: lookup / fill / invalidate-line / flush-all.
// Round-robin victim per set; flush walks one set per cycle with the block busy.
module assoc_tag_cache #(
  parameter  int ADDR_W   = 32,
  parameter  int INDEX_W  = 6,
  parameter  int OFFSET_W = 0,
  parameter  int WAYS     = 2,
  localparam int SETS     = 2**INDEX_W,
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W,
  localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  output logic              rsp_hit,
  output logic [WAY_W-1:0]  rsp_way,
  output logic              busy,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
);

  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;
  typedef enum logic [1:0] {OP_LOOKUP = 2'b00, OP_FILL = 2'b01,
                            OP_INVAL = 2'b10, OP_FLUSH = 2'b11} op_t;

  typedef struct packed {
    op_t                op;
    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
  } req_t;

  state_t state_q, state_d;
  logic [INDEX_W-1:0] flush_idx_q;

  logic [SETS-1:0][WAYS-1:0]  valid_q;
  logic [SETS-1:0][WAY_W-1:0] ptr_q;
  logic [TAG_W-1:0]           tag_q [SETS][WAYS];

  req_t req;
  assign req.op  = op_t'(req_op);
  assign req.idx = req_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
  assign req.tag = req_addr[ADDR_W-1:INDEX_W+OFFSET_W];

  assign busy      = (state_q == FLUSH);
  assign req_ready = !busy;

  logic accept;
  assign accept = req_valid && req_ready;

  logic [WAYS-1:0] match;
  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign match[w] = valid_q[req.idx][w] && (tag_q[req.idx][w] == req.tag);
  end

  // Descending scan so the lowest-numbered way wins for both hit and free slot.
  logic             hit, free;
  logic [WAY_W-1:0] hit_way, free_way, fill_way, ptr_inc;
  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    free     = 1'b0;
    free_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (match[w]) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[req.idx][w]) begin
        free     = 1'b1;
        free_way = WAY_W'(w);
      end
    end
    fill_way = free ? free_way : ptr_q[req.idx];
    ptr_inc  = (WAYS == 1) ? '0 : ptr_q[req.idx] + WAY_W'(1);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && req.op == OP_FLUSH) state_d = FLUSH;
      FLUSH:   if (flush_idx_q == INDEX_W'(SETS - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Registered so the flush response lands on the final busy cycle.
  logic flush_pulse;
  assign flush_pulse = busy && (flush_idx_q == INDEX_W'(SETS - 2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_idx_q <= '0;
      valid_q     <= '0;
      ptr_q       <= '0;
      rsp_valid   <= 1'b0;
      rsp_hit     <= 1'b0;
      rsp_way     <= '0;
      hit_count   <= '0;
      miss_count  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_hit   <= 1'b0;
      rsp_way   <= '0;
      if (busy) begin
        valid_q[flush_idx_q] <= '0;
        ptr_q[flush_idx_q]   <= '0;
        flush_idx_q          <= flush_idx_q + INDEX_W'(1);
        rsp_valid            <= flush_pulse;
      end else if (accept) begin
        rsp_valid <= (req.op != OP_FLUSH);
        case (req.op)
          OP_LOOKUP: begin
            rsp_hit <= hit;
            rsp_way <= hit ? hit_way : '0;
            if (hit) begin
              if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
            end else begin
              if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
            end
          end
          OP_FILL: begin
            rsp_hit <= hit;
            rsp_way <= hit ? hit_way : fill_way;
            if (!hit) begin
              valid_q[req.idx][fill_way] <= 1'b1;
              if (!free) ptr_q[req.idx] <= ptr_inc;
            end
          end
          OP_INVAL: begin
            rsp_hit <= hit;
            rsp_way <= hit ? hit_way : '0;
            if (hit) valid_q[req.idx][hit_way] <= 1'b0;
          end
          default: flush_idx_q <= '0;
        endcase
      end
    end
  end

  // Tags carry no reset; a line is only meaningful behind its valid bit.
  always_ff @(posedge clk) begin
    if (accept && req.op == OP_FILL && !hit)
      tag_q[req.idx][fill_way] <= req.tag;
  end

endmodule

// File: tb/tb_assoc_tag_cache.sv
// Randomized scoreboard bench for assoc_tag_cache against a per-set way-list model.
module tb_assoc_tag_cache;
  localparam int ADDR_W = 32, INDEX_W = 6, OFFSET_W = 0, WAYS = 2;
  localparam int SETS = 2**INDEX_W, WAY_W = 1, TAG_W = ADDR_W - INDEX_W;

  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_ready;
  logic [1:0] req_op = 2'b00;
  logic [ADDR_W-1:0] req_addr = '0;
  logic rsp_valid, rsp_hit, busy;
  logic [WAY_W-1:0] rsp_way;
  logic [15:0] hit_count, miss_count;

  assoc_tag_cache #(.ADDR_W(ADDR_W), .INDEX_W(INDEX_W), .OFFSET_W(OFFSET_W), .WAYS(WAYS)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .rsp_valid(rsp_valid), .rsp_hit(rsp_hit),
    .rsp_way(rsp_way), .busy(busy), .hit_count(hit_count), .miss_count(miss_count));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  typedef struct {bit hit; int way; int hc; int mc;} exp_t;
  exp_t sbq[$];

  // Reference model: per set, a list of (valid, tag) per way plus victim pointer.
  bit              mv [SETS][WAYS];
  logic [TAG_W-1:0] mt [SETS][WAYS];
  int              mp [SETS];
  int              mhc, mmc;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mreset();
    for (int s = 0; s < SETS; s++) begin
      mp[s] = 0;
      for (int w = 0; w < WAYS; w++) mv[s][w] = 0;
    end
    mhc = 0;
    mmc = 0;
    sbq.delete();
  endtask

  task automatic model(input logic [1:0] op, input logic [ADDR_W-1:0] addr, output exp_t e);
    int s, hw, iw;
    logic [TAG_W-1:0] t;
    s = int'(addr[INDEX_W+OFFSET_W-1:OFFSET_W]);
    t = addr[ADDR_W-1:INDEX_W+OFFSET_W];
    hw = -1;
    iw = -1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (mv[s][w] && mt[s][w] == t) hw = w;
      if (!mv[s][w]) iw = w;
    end
    e.hit = (hw >= 0);
    e.way = (hw >= 0) ? hw : 0;
    case (op)
      2'b00: if (hw >= 0) mhc = (mhc < 65535) ? mhc + 1 : mhc;
             else         mmc = (mmc < 65535) ? mmc + 1 : mmc;
      2'b01: if (hw < 0) begin
               if (iw < 0) begin
                 iw = mp[s];
                 mp[s] = (mp[s] + 1) % WAYS;
               end
               mv[s][iw] = 1;
               mt[s][iw] = t;
               e.way = iw;
             end
      2'b10: if (hw >= 0) mv[s][hw] = 0;
      default: begin
        for (int i = 0; i < SETS; i++) begin
          mp[i] = 0;
          for (int w = 0; w < WAYS; w++) mv[i][w] = 0;
        end
        e.hit = 0;
        e.way = 0;
      end
    endcase
    e.hc = mhc;
    e.mc = mmc;
  endtask

  // Hold the request until accepted; report wait length and when rsp_valid showed.
  task automatic issue(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                       output int waited, output int rsp_at);
    exp_t e;
    waited = 0;
    rsp_at = -1;
    @(negedge clk);
    req_valid = 1'b1;
    req_op = op;
    req_addr = addr;
    while (!req_ready && waited < 200) begin
      if (rsp_valid) rsp_at = waited;
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    model(op, addr, e);
    if (op != 2'b11 || 1'b1) sbq.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic go(input logic [1:0] op, input logic [ADDR_W-1:0] addr);
    int w, r;
    issue(op, addr, w, r);
  endtask

  exp_t me;
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid) begin
        if (sbq.size() == 0) chk("unexpected_rsp", 1, 0);
        else begin
          me = sbq.pop_front();
          chk("rsp_hit", rsp_hit, me.hit);
          chk("rsp_way", rsp_way, me.way);
          chk("hit_count", hit_count, me.hc);
          chk("miss_count", miss_count, me.mc);
        end
      end else begin
        chk("rsp_idle_zero", {rsp_hit, rsp_way}, 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  function automatic logic [ADDR_W-1:0] mk(input int tag, input int set);
    mk = ADDR_W'((tag << INDEX_W) | set);
  endfunction

  initial begin
    int w, r, op, rr;
    logic [ADDR_W-1:0] a;
    mreset();
    #23;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_counts", {hit_count, miss_count}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed: miss, fill, back-to-back hit.
    go(2'b00, 32'h0000_1040);
    go(2'b01, 32'h0000_1040);
    go(2'b00, 32'h0000_1040);
    // Three tags into set 5 with two ways.
    go(2'b01, mk(10, 5));
    go(2'b01, mk(11, 5));
    go(2'b01, mk(12, 5));
    go(2'b00, mk(10, 5));
    go(2'b00, mk(11, 5));
    go(2'b00, mk(12, 5));
    go(2'b01, mk(11, 5));
    go(2'b01, mk(13, 5));
    go(2'b10, mk(12, 5));
    go(2'b10, mk(12, 5));

    // Flush with a request held across busy.
    go(2'b01, mk(3, 63));
    go(2'b11, 32'h0);
    issue(2'b00, mk(3, 63), w, r);
    chk("flush_busy_cycles", w, SETS);
    chk("flush_rsp_cycle", r, SETS - 1);
    go(2'b00, mk(11, 5));

    // Random mix over a few colliding sets.
    for (int i = 0; i < 1500; i++) begin
      rr = $urandom_range(0, 99);
      op = (rr < 45) ? 0 : (rr < 80) ? 1 : (rr < 99) ? 2 : 3;
      case ($urandom_range(0, 3))
        0: a = mk($urandom_range(0, 4), 0);
        1: a = mk($urandom_range(0, 4), 1);
        2: a = mk($urandom_range(0, 4), 5);
        default: a = mk($urandom_range(0, 4), 63);
      endcase
      go(2'(op), a);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    // Reset pulse mid-flush.
    go(2'b01, mk(7, 1));
    go(2'b11, 32'h0);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midflush_busy", busy, 0);
    chk("midflush_ready", req_ready, 1);
    mreset();
    @(negedge clk);
    rst_n = 1'b1;
    go(2'b00, mk(7, 1));
    go(2'b00, mk(11, 5));

    // Saturating miss counter.
    @(negedge clk);
    rst_n = 1'b0;
    mreset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 65537; i++) go(2'b00, 32'h0000_1040);
    repeat (2) @(negedge clk);
    chk("miss_sat", miss_count, 16'hFFFF);
    chk("hit_zero", hit_count, 0);
    chk("sb_drained", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
